// File: rtl/nrzi_destuff_rx.sv
// USB receive front end: per-strobe NRZI decode of D+/D-, removal of stuffed zeros,
// and EOP / line-error detection with its own packet-activity state machine.
module nrzi_destuff_rx #(
    parameter int   STUFF_LEN    = 6,
    parameter logic IDLE_LEVEL   = 1'b1,
    parameter int   EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic strobe,
    input  logic flush,
    output logic d_orig,
    output logic d_valid,
    output logic rx_active,
    output logic eop,
    output logic rx_err
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int SE0_W  = $clog2(EOP_SE0_BITS + 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
    localparam logic [SE0_W-1:0]  SE0_MIN  = SE0_W'(EOP_SE0_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SE0    = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_prev_lvl;
    logic [ONES_W-1:0]   r_ones_cnt;
    logic [SE0_W-1:0]    r_se0_cnt;

    logic                w_is_j;
    logic                w_is_k;
    logic                w_is_se0;
    logic                w_is_se1;
    logic                w_bit;
    logic                w_ones_full;
    logic                w_se0_qual;
    logic [SE0_W-1:0]    w_se0_next;

    assign w_is_j      = (d_plus == IDLE_LEVEL) && (d_minus != IDLE_LEVEL);
    assign w_is_k      = (d_plus != IDLE_LEVEL) && (d_minus == IDLE_LEVEL);
    assign w_is_se0    = !d_plus && !d_minus;
    assign w_is_se1    = d_plus && d_minus;

    // NRZI: an unchanged line level carries a one, a transition carries a zero.
    assign w_bit       = (d_plus == r_prev_lvl);
    assign w_ones_full = (r_ones_cnt == ONES_MAX);
    assign w_se0_qual  = (r_se0_cnt >= SE0_MIN);
    assign w_se0_next  = w_se0_qual ? r_se0_cnt : r_se0_cnt + SE0_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_prev_lvl <= IDLE_LEVEL;
            r_ones_cnt <= '0;
            r_se0_cnt  <= '0;
            d_orig     <= 1'b1;
            d_valid    <= 1'b0;
            rx_active  <= 1'b0;
            eop        <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            eop     <= 1'b0;
            rx_err  <= 1'b0;

            if (flush) begin
                r_state    <= ST_IDLE;
                rx_active  <= 1'b0;
                r_prev_lvl <= IDLE_LEVEL;
                r_ones_cnt <= '0;
                r_se0_cnt  <= '0;
            end else if (strobe) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_k) begin
                            r_state    <= ST_ACTIVE;
                            rx_active  <= 1'b1;
                            d_orig     <= w_bit;
                            d_valid    <= 1'b1;
                            r_prev_lvl <= d_plus;
                            r_ones_cnt <= ONES_W'(w_bit);
                        end else if (w_is_se1) begin
                            r_state   <= ST_ERROR;
                            rx_err    <= 1'b1;
                            r_se0_cnt <= '0;
                        end
                    end

                    ST_ACTIVE: begin
                        if (w_is_j || w_is_k) begin
                            r_prev_lvl <= d_plus;
                            if (!w_ones_full) begin
                                d_orig     <= w_bit;
                                d_valid    <= 1'b1;
                                r_ones_cnt <= w_bit ? r_ones_cnt + ONES_W'(1) : '0;
                            end else if (!w_bit) begin
                                // Stuffed zero after a full run of ones: consumed silently.
                                r_ones_cnt <= '0;
                            end else begin
                                r_state   <= ST_ERROR;
                                rx_err    <= 1'b1;
                                r_se0_cnt <= '0;
                            end
                        end else if (w_is_se0) begin
                            r_state   <= ST_SE0;
                            r_se0_cnt <= SE0_W'(1);
                        end else begin
                            r_state   <= ST_ERROR;
                            rx_err    <= 1'b1;
                            r_se0_cnt <= '0;
                        end
                    end

                    ST_SE0: begin
                        if (w_is_se0) begin
                            r_se0_cnt <= w_se0_next;
                        end else if (w_is_j && w_se0_qual) begin
                            r_state    <= ST_IDLE;
                            eop        <= 1'b1;
                            rx_active  <= 1'b0;
                            r_prev_lvl <= IDLE_LEVEL;
                            r_ones_cnt <= '0;
                            r_se0_cnt  <= '0;
                        end else begin
                            r_state   <= ST_ERROR;
                            rx_err    <= 1'b1;
                            r_se0_cnt <= '0;
                        end
                    end

                    default: begin
                        // Error recovery waits for a properly qualified EOP.
                        if (w_is_se0) begin
                            r_se0_cnt <= w_se0_next;
                        end else if (w_is_j && w_se0_qual) begin
                            r_state    <= ST_IDLE;
                            eop        <= 1'b1;
                            rx_active  <= 1'b0;
                            r_prev_lvl <= IDLE_LEVEL;
                            r_ones_cnt <= '0;
                            r_se0_cnt  <= '0;
                        end else begin
                            r_se0_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nrzi_destuff_rx.sv
// Bench for nrzi_destuff_rx: two instances (full-speed polarity with 6-bit stuffing, and
// inverted polarity with 3-bit stuffing) driven by the same symbolic line stream.
module tb_nrzi_destuff_rx;

    localparam int S_A = 6;
    localparam int S_B = 3;
    localparam int E   = 2;

    typedef enum logic [1:0] {SYM_J, SYM_K, SYM_SE0, SYM_SE1} sym_t;

    typedef struct packed {
        logic dv;
        logic bt;
        logic ev;
        logic er;
        logic act;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst;
    logic strobe;
    logic flush;
    sym_t cur_line;
    sym_t enc;

    logic dp_a, dm_a, dp_b, dm_b;
    logic a_orig, a_valid, a_act, a_eop, a_err;
    logic b_orig, b_valid, b_act, b_eop, b_err;

    int n_checks = 0;
    int n_err    = 0;

    exp_t qa[$];
    exp_t qb[$];

    int   m_mode [2];
    sym_t m_last [2];
    int   m_ones [2];
    int   m_se0  [2];
    bit   m_act  [2];

    int   a_nv, a_ne, a_nr, b_nv, b_ne, b_nr;
    logic [63:0] a_bits, b_bits;

    always #5 clk = ~clk;

    assign dp_a = (cur_line == SYM_J) || (cur_line == SYM_SE1);
    assign dm_a = (cur_line == SYM_K) || (cur_line == SYM_SE1);
    assign dp_b = (cur_line == SYM_K) || (cur_line == SYM_SE1);
    assign dm_b = (cur_line == SYM_J) || (cur_line == SYM_SE1);

    nrzi_destuff_rx #(.STUFF_LEN(S_A), .IDLE_LEVEL(1'b1), .EOP_SE0_BITS(E)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .d_plus(dp_a), .d_minus(dm_a),
        .strobe(strobe), .flush(flush),
        .d_orig(a_orig), .d_valid(a_valid), .rx_active(a_act), .eop(a_eop), .rx_err(a_err)
    );

    nrzi_destuff_rx #(.STUFF_LEN(S_B), .IDLE_LEVEL(1'b0), .EOP_SE0_BITS(E)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .d_plus(dp_b), .d_minus(dm_b),
        .strobe(strobe), .flush(flush),
        .d_orig(b_orig), .d_valid(b_valid), .rx_active(b_act), .eop(b_eop), .rx_err(b_err)
    );

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic dv, input logic bt, input logic ev,
                             input logic er, input logic act, input exp_t e);
        chk({tag, "_d_valid"}, dv, e.dv);
        chk({tag, "_eop"}, ev, e.ev);
        chk({tag, "_rx_err"}, er, e.er);
        chk({tag, "_rx_active"}, act, e.act);
        if (e.dv) chk({tag, "_d_orig"}, bt, e.bt);
    endtask

    task automatic model_idle(input int m);
        m_mode[m] = 0;
        m_last[m] = SYM_J;
        m_ones[m] = 0;
        m_se0[m]  = 0;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            model_idle(m);
            m_act[m] = 1'b0;
        end
    endtask

    // Packet-level model: mode 0 idle, 1 receiving data, 2 inside an SE0 run, 3 error.
    task automatic model_step(input sym_t s, input bit stb, input bit fl);
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            int   lim;
            bit   b;
            lim = (m == 0) ? S_A : S_B;
            e   = '0;
            b   = (s == m_last[m]);
            if (fl) begin
                model_idle(m);
                m_act[m] = 1'b0;
            end else if (stb) begin
                case (m_mode[m])
                    0: begin
                        if (s == SYM_K) begin
                            e.dv = 1'b1; e.bt = b;
                            m_last[m] = s; m_ones[m] = b ? 1 : 0;
                            m_mode[m] = 1; m_act[m] = 1'b1;
                        end else if (s == SYM_SE1) begin
                            e.er = 1'b1; m_mode[m] = 3; m_se0[m] = 0;
                        end
                    end
                    1: begin
                        if (s == SYM_J || s == SYM_K) begin
                            m_last[m] = s;
                            if (m_ones[m] < lim) begin
                                e.dv = 1'b1; e.bt = b;
                                m_ones[m] = b ? m_ones[m] + 1 : 0;
                            end else if (!b) begin
                                m_ones[m] = 0;
                            end else begin
                                e.er = 1'b1; m_mode[m] = 3; m_se0[m] = 0;
                            end
                        end else if (s == SYM_SE0) begin
                            m_mode[m] = 2; m_se0[m] = 1;
                        end else begin
                            e.er = 1'b1; m_mode[m] = 3; m_se0[m] = 0;
                        end
                    end
                    2: begin
                        if (s == SYM_SE0) m_se0[m]++;
                        else if (s == SYM_J && m_se0[m] >= E) begin
                            e.ev = 1'b1; m_act[m] = 1'b0; model_idle(m);
                        end else begin
                            e.er = 1'b1; m_mode[m] = 3; m_se0[m] = 0;
                        end
                    end
                    default: begin
                        if (s == SYM_SE0) m_se0[m]++;
                        else if (s == SYM_J && m_se0[m] >= E) begin
                            e.ev = 1'b1; m_act[m] = 1'b0; model_idle(m);
                        end else m_se0[m] = 0;
                    end
                endcase
            end
            e.act = m_act[m];
            if (m == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    // Compare process: one expectation per clock, checked 1 time unit after the edge.
    always begin : cmp
        exp_t ea;
        exp_t eb;
        @(posedge clk);
        #1;
        if (n_rst && qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            check_dut("A", a_valid, a_orig, a_eop, a_err, a_act, ea);
            check_dut("B", b_valid, b_orig, b_eop, b_err, b_act, eb);
            if (a_eop) chk("A_eop_with_rx_active_low", a_act, 0);
            if (a_valid) begin a_nv++; a_bits = {a_bits[62:0], a_orig}; end
            if (b_valid) begin b_nv++; b_bits = {b_bits[62:0], b_orig}; end
            if (a_eop) a_ne++;
            if (a_err) a_nr++;
            if (b_eop) b_ne++;
            if (b_err) b_nr++;
        end
    end

    task automatic cyc(input sym_t s, input bit stb, input bit fl);
        @(negedge clk);
        cur_line = s;
        strobe   = stb;
        flush    = fl;
        model_step(s, stb, fl);
    endtask

    task automatic send_sym(input sym_t s);
        cyc(s, 1'b1, 1'b0);
        cyc(s, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input bit b);
        if (!b) enc = (enc == SYM_J) ? SYM_K : SYM_J;
        send_sym(enc);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(SYM_J, 1'b0, 1'b0);
    endtask

    task automatic eop_seq();
        send_sym(SYM_SE0);
        send_sym(SYM_SE0);
        send_sym(SYM_J);
    endtask

    task automatic clr();
        a_nv = 0; a_ne = 0; a_nr = 0; a_bits = '0;
        b_nv = 0; b_ne = 0; b_nr = 0; b_bits = '0;
        enc  = SYM_J;
    endtask

    initial begin
        logic [7:0] pid;
        n_rst = 1'b0; strobe = 1'b0; flush = 1'b0; cur_line = SYM_J;
        model_reset();
        clr();
        repeat (3) @(negedge clk);
        chk("reset_d_orig", a_orig, 1);
        chk("reset_d_valid", a_valid, 0);
        chk("reset_rx_active", a_act, 0);
        chk("reset_eop", a_eop, 0);
        chk("reset_rx_err", a_err, 0);
        chk("reset_B_d_orig", b_orig, 1);
        n_rst = 1'b1;
        idle(2);
        send_sym(SYM_J);
        send_sym(SYM_J);

        // Sync KJKJKJKK + PID 0xE1 + EOP
        clr();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        pid = 8'hE1;
        for (int i = 0; i < 8; i++) send_bit(pid[i]);
        eop_seq();
        idle(3);
        chk("sync_pid_A_count", a_nv, 16);
        chk("sync_pid_A_bits", int'(a_bits[15:0]), 16'h0187);
        chk("sync_pid_A_eops", a_ne, 1);
        chk("sync_pid_A_errs", a_nr, 0);
        chk("sync_pid_B_count", b_nv, 16);
        chk("sync_pid_B_bits", int'(b_bits[15:0]), 16'h0187);

        // 1111110 then 1: stuffed zero dropped in A, run-length violation in B
        clr();
        send_bit(1'b0);
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        eop_seq();
        idle(3);
        chk("stuff6_A_count", a_nv, 8);
        chk("stuff6_A_bits", int'(a_bits[7:0]), 8'h7F);
        chk("stuff6_A_errs", a_nr, 0);
        chk("stuff6_A_eops", a_ne, 1);
        chk("stuff6_B_count", b_nv, 4);
        chk("stuff6_B_errs", b_nr, 1);
        chk("stuff6_B_eops", b_ne, 1);

        // 111 then stuffed 0 then 1: dropped in B
        clr();
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        eop_seq();
        idle(3);
        chk("stuff3_A_bits", int'(a_bits[5:0]), 6'h1D);
        chk("stuff3_B_count", b_nv, 5);
        chk("stuff3_B_bits", int'(b_bits[4:0]), 5'h0F);
        chk("stuff3_B_errs", b_nr, 0);

        // Seven ones with no stuffed zero
        clr();
        send_bit(1'b0);
        repeat (7) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        eop_seq();
        idle(3);
        chk("seven_ones_A_count", a_nv, 7);
        chk("seven_ones_A_bits", int'(a_bits[6:0]), 7'h3F);
        chk("seven_ones_A_errs", a_nr, 1);
        chk("seven_ones_A_eops", a_ne, 1);

        // Short EOP: one SE0 then J
        clr();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_sym(SYM_SE0);
        send_sym(SYM_J);
        idle(2);
        chk("short_eop_A_errs", a_nr, 1);
        chk("short_eop_A_eops", a_ne, 0);
        eop_seq();
        idle(3);
        chk("short_eop_recover_A_eops", a_ne, 1);
        chk("short_eop_A_count", a_nv, 3);

        // SE1 mid-packet
        clr();
        send_bit(1'b0);
        send_bit(1'b1);
        send_sym(SYM_SE1);
        idle(2);
        chk("se1_A_errs", a_nr, 1);
        chk("se1_B_errs", b_nr, 1);
        eop_seq();
        idle(3);
        chk("se1_A_eops", a_ne, 1);
        chk("se1_A_count", a_nv, 2);

        // Flush together with a strobe, line left at K
        clr();
        send_bit(1'b0);
        send_bit(1'b1);
        cyc(SYM_K, 1'b1, 1'b1);
        cyc(SYM_K, 1'b0, 1'b0);
        idle(2);
        chk("flush_A_count", a_nv, 2);
        chk("flush_A_rx_active", a_act, 0);
        chk("flush_B_rx_active", b_act, 0);
        clr();
        send_sym(SYM_K);
        eop_seq();
        idle(3);
        chk("after_flush_A_count", a_nv, 1);
        chk("after_flush_A_bit", int'(a_bits[0]), 0);
        chk("after_flush_A_eops", a_ne, 1);

        // Asynchronous reset in the middle of a packet
        clr();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_rst_A_d_orig", a_orig, 1);
        chk("async_rst_A_rx_active", a_act, 0);
        chk("async_rst_A_d_valid", a_valid, 0);
        chk("async_rst_B_rx_active", b_act, 0);
        qa.delete();
        qb.delete();
        model_reset();
        strobe = 1'b0; flush = 1'b0; cur_line = SYM_J;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        clr();
        send_sym(SYM_K);
        eop_seq();
        idle(3);
        chk("after_rst_A_count", a_nv, 1);
        chk("after_rst_A_eops", a_ne, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
